mux_mult_seq: RTL

- Parametrised, iterative unsigned/signed multiplier built from the same mux-select partial-product idea as the array cells: each multiplier bit selects x or 0, and that value is added into a running sum.
- Processes STEP multiplier bits per clock, so it trades latency for area compared with the full combinational array.
- Sits on a valid/ready stream: operands come in, one 2*WIDTH product goes out.

---
 rtl/mux_mult_seq_if.sv | 27 ++
 rtl/mux_mult_seq.sv | 132 +++++++++++++
 2 files changed

// File: rtl/mux_mult_seq_if.sv
// Stream interface for the sequential mux-select multiplier.
// Operands go in on the in_* side and the 2*WIDTH product comes out on the out_* side.
interface mux_mult_seq_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   x;
  logic [WIDTH-1:0]   y;
  logic               signed_mode;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  // Producer of operands and consumer of products.
  modport master (
    output in_valid, x, y, signed_mode, out_ready,
    input  in_ready, out_valid, product, busy
  );

  // The multiplier itself.
  modport slave (
    input  in_valid, x, y, signed_mode, out_ready,
    output in_ready, out_valid, product, busy
  );
endinterface

// File: rtl/mux_mult_seq.sv
// Iterative shift-and-add multiplier: each cycle STEP multiplier bits each
// select the (shifted) multiplicand or zero, and the selected values are summed
// into a 2*WIDTH accumulator. Signed operation multiplies magnitudes and
// negates the final sum when the operand signs differ.
module mux_mult_seq #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic           clk,
  input  logic           reset,
  mux_mult_seq_if.slave  bus
);
  localparam int N  = WIDTH / ((STEP < 1) ? 1 : STEP);
  localparam int PW = 2 * WIDTH;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  // Reject parameter sets where STEP does not evenly split the multiplier.
  generate
    if (WIDTH < 2 || STEP < 1 || (WIDTH % ((STEP < 1) ? 1 : STEP)) != 0) begin : g_param_check
      $error("mux_mult_seq: WIDTH must be >= 2 and STEP must divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_reg, state_next;
  logic [PW-1:0]     mcand_reg;     // multiplicand, pre-shifted to the current bit weight
  logic [WIDTH-1:0]  mplier_reg;    // remaining multiplier bits, LSB is consumed first
  logic [PW-1:0]     acc_reg;
  logic [CW-1:0]     cnt_reg;
  logic              neg_reg;
  logic [PW-1:0]     product_reg;

  logic              in_ready_c;
  logic              accept;
  logic              x_neg, y_neg;
  logic [WIDTH-1:0]  x_mag, y_mag;
  logic [PW-1:0]     pp [STEP];
  logic [PW-1:0]     sum_next;
  logic [PW-1:0]     final_val;

  // Magnitudes: -2^(W-1) negates to itself, which read unsigned is exactly 2^(W-1).
  assign x_neg  = bus.signed_mode & bus.x[WIDTH-1];
  assign y_neg  = bus.signed_mode & bus.y[WIDTH-1];
  assign x_mag  = x_neg ? -bus.x : bus.x;
  assign y_mag  = y_neg ? -bus.y : bus.y;
  assign accept = bus.in_valid & in_ready_c;

  // One mux-select partial product per multiplier bit handled this cycle.
  generate
    for (genvar gi = 0; gi < STEP; gi++) begin : g_pp
      assign pp[gi] = mplier_reg[gi] ? (mcand_reg << gi) : '0;
    end
  endgenerate

  // Running sum after folding in this cycle's partial products.
  always_comb begin
    sum_next = acc_reg;
    for (int i = 0; i < STEP; i++) begin
      sum_next = sum_next + pp[i];
    end
  end

  assign final_val = neg_reg ? -sum_next : sum_next;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and handshake outputs; in_ready is held low while reset is asserted.
  always_comb begin
    state_next    = state_reg;
    in_ready_c    = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b1;
    case (state_reg)
      IDLE: begin
        in_ready_c = ~reset;
        bus.busy   = 1'b0;
        if (bus.in_valid && !reset) state_next = RUN;
      end
      RUN: begin
        if (cnt_reg == '0) state_next = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.in_ready = in_ready_c;
  assign bus.product  = product_reg;

  // Datapath: operand capture on accept, accumulate in RUN, publish on the last RUN edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      neg_reg     <= 1'b0;
      product_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            mcand_reg  <= {{WIDTH{1'b0}}, x_mag};
            mplier_reg <= y_mag;
            neg_reg    <= x_neg ^ y_neg;
            acc_reg    <= '0;
            cnt_reg    <= CW'(N - 1);
          end
        end
        RUN: begin
          acc_reg    <= sum_next;
          mcand_reg  <= mcand_reg << STEP;
          mplier_reg <= mplier_reg >> STEP;
          cnt_reg    <= cnt_reg - CW'(1);
          if (cnt_reg == '0) product_reg <= final_val;
        end
        default: ;
      endcase
    end
  end
endmodule
